poly_dds_acc: RTL and testbench
===============================

POLY_DDS_ACC -- requirements
Module: poly_dds_acc

Interface
REQ-001 Parameter CH, default 4: number of independent phase-accumulator channels (voices).
REQ-002 Parameter ACC_W, default 25: phase accumulator width per channel.
REQ-003 Parameter FCW_W, default 16: base frequency control word width per channel.
REQ-004 Parameter MULT_W, default 3: scale-degree multiplier width.
REQ-005 clk  input  1: single clock; all state SHALL update on its rising edge.
REQ-006 rst_n  input  1: reset, asynchronous assert, active-low.
REQ-007 key_n  input  CH: per-channel key, active-low, asynchronous to clk.
REQ-008 fcw  input  CH*FCW_W: per-channel base FCW; channel i occupies bits [i*FCW_W +: FCW_W].
REQ-009 mult_a  input  MULT_W: multiplier used when mode=0.
REQ-010 mult_b  input  MULT_W: multiplier used when mode=1.
REQ-011 mode  input  1: multiplier source select (0 = free play, 1 = guided/box).
REQ-012 tick  input  1: sample-rate enable; accumulators advance only on cycles with tick=1.
REQ-013 phase  output  CH*ACC_W: per-channel phase; channel i at bits [i*ACC_W +: ACC_W].
REQ-014 active  output  CH: per-channel voice-active flag.
REQ-015 wrap  output  CH: per-channel one-cycle pulse on accumulator overflow.

Function
REQ-016 Each key_n bit SHALL pass through a 2-flop synchroniser followed by one previous-value register; press = synced 1->0, release = synced 0->1.
REQ-017 A key_n change held stable SHALL produce its press/release action at the 3rd rising edge after it is first sampled.
REQ-018 On press of channel i: step_i <= fcw_i * (mode ? mult_b : mult_a), full FCW_W+MULT_W bits, no truncation; phase_i <= 0; active_i <= 1; wrap_i <= 0.
REQ-019 step_i SHALL be latched only on press; fcw, mult_a, mult_b, mode changes while the key is held SHALL NOT affect channel i.
REQ-020 While active_i=1 and tick=1 with no press/release event that cycle: phase_i <= (phase_i + zero-extended step_i) mod 2^ACC_W.
REQ-021 wrap_i SHALL be 1 for exactly the cycle following an update in which the addition carried out of bit ACC_W-1; otherwise 0.
REQ-022 While active_i=1 and tick=0: phase_i holds, wrap_i=0.
REQ-023 On release of channel i: phase_i <= 0, active_i <= 0, wrap_i <= 0 in that cycle, regardless of tick.
REQ-024 While active_i=0: phase_i, wrap_i SHALL remain 0 and step_i ignored.
REQ-025 Press or release coinciding with tick=1 SHALL take priority; no accumulation occurs on that cycle.
REQ-026 step_i=0 (fcw or multiplier zero): channel active with phase held at 0, no wrap.
REQ-027 If step_i >= 2^ACC_W, only the modular sum is kept; wrap asserts on every carry.
REQ-028 Channels SHALL be fully independent; simultaneous events on different channels each take effect the same cycle.

Reset
REQ-029 rst_n=0 SHALL immediately clear phase, active, wrap, all step registers and all synchroniser/edge registers to 0, without clock.
REQ-030 Synchroniser registers SHALL reset to 0; a key held low through reset deassertion is NOT treated as a press until released and pressed again.

Verification
REQ-031 Reset: rst_n=0 mid-accumulation, no clk edge -> phase=0, active=0, wrap=0 immediately.
REQ-032 Press ch0, fcw0=1000, mode=0, mult_a=3, tick=1 continuous -> active0=1 at edge 3, phase0 = 0, 3000, 6000, 9000 on successive cycles.
REQ-033 Wrap: fcw0=0xFFFF, mult_a=7 (step 458745), ACC_W=25 -> after 74th tick phase0=392698, wrap0=1 for one cycle, wrap0=0 on ticks 1-73.
REQ-034 Hold: after press with step 3000, change fcw0=5, mode=1, mult_b=7 -> increments stay 3000; tick low 10 cycles -> phase0 unchanged.
REQ-035 Simultaneous: ch0 release and ch1 press (fcw1=200, mult_a=2) same cycle -> phase0=0/active0=0 and phase1=0/active1=1 same edge, then phase1 +400 per tick.
REQ-036 key_n0 held low across rst_n deassertion -> active0 stays 0; release then press -> normal press behaviour.

Source files
------------

// File: rtl/poly_dds_acc_if.sv
// Bus for the polyphonic DDS phase accumulator: per-channel keys and frequency
// words in, per-channel phase/active/wrap out.
interface poly_dds_acc_if #(
    parameter int CH     = 4,
    parameter int ACC_W  = 25,
    parameter int FCW_W  = 16,
    parameter int MULT_W = 3
);
    logic [CH-1:0]       key_n;
    logic [CH*FCW_W-1:0] fcw;
    logic [MULT_W-1:0]   mult_a;
    logic [MULT_W-1:0]   mult_b;
    logic                mode;
    logic                tick;
    logic [CH*ACC_W-1:0] phase;
    logic [CH-1:0]       active;
    logic [CH-1:0]       wrap;

    modport master (
        output key_n, fcw, mult_a, mult_b, mode, tick,
        input  phase, active, wrap
    );

    modport slave (
        input  key_n, fcw, mult_a, mult_b, mode, tick,
        output phase, active, wrap
    );
endinterface

// File: rtl/poly_dds_acc.sv
// Polyphonic DDS phase accumulator: each channel latches fcw*multiplier on key
// press and advances its phase on every tick while the key is held.
module poly_dds_acc #(
    parameter int CH     = 4,
    parameter int ACC_W  = 25,
    parameter int FCW_W  = 16,
    parameter int MULT_W = 3
) (
    input logic           clk,
    input logic           rst_n,
    poly_dds_acc_if.slave bus
);
    localparam int STEP_W = FCW_W + MULT_W;
    localparam int EXT_W  = (STEP_W > ACC_W) ? STEP_W : ACC_W;

    logic [MULT_W-1:0] mult_sel;
    assign mult_sel = bus.mode ? bus.mult_b : bus.mult_a;

    generate
        for (genvar gi = 0; gi < CH; gi++) begin : g_ch
            logic              s1_q, s1_d;
            logic              s2_q, s2_d;
            logic              prev_q, prev_d;
            logic              press;
            logic              rel_ev;
            logic [STEP_W-1:0] step_q, step_d;
            logic [ACC_W-1:0]  phase_q, phase_d;
            logic              active_q, active_d;
            logic              wrap_q, wrap_d;
            logic [EXT_W-1:0]  step_ext;
            logic [ACC_W:0]    sum;

            // Only the low ACC_W bits of the step matter modulo 2^ACC_W.
            assign step_ext = EXT_W'(step_q);
            assign sum      = {1'b0, phase_q} + {1'b0, step_ext[ACC_W-1:0]};

            always_comb begin
                s1_d     = bus.key_n[gi];
                s2_d     = s1_q;
                prev_d   = s2_q;
                press    = prev_q & ~s2_q;
                rel_ev   = ~prev_q & s2_q;
                step_d   = step_q;
                phase_d  = phase_q;
                active_d = active_q;
                wrap_d   = 1'b0;
                if (press) begin
                    step_d   = STEP_W'(bus.fcw[gi*FCW_W +: FCW_W]) * STEP_W'(mult_sel);
                    phase_d  = '0;
                    active_d = 1'b1;
                end else if (rel_ev) begin
                    phase_d  = '0;
                    active_d = 1'b0;
                end else if (active_q && bus.tick) begin
                    phase_d = sum[ACC_W-1:0];
                    wrap_d  = sum[ACC_W];
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s1_q     <= 1'b0;
                    s2_q     <= 1'b0;
                    prev_q   <= 1'b0;
                    step_q   <= '0;
                    phase_q  <= '0;
                    active_q <= 1'b0;
                    wrap_q   <= 1'b0;
                end else begin
                    s1_q     <= s1_d;
                    s2_q     <= s2_d;
                    prev_q   <= prev_d;
                    step_q   <= step_d;
                    phase_q  <= phase_d;
                    active_q <= active_d;
                    wrap_q   <= wrap_d;
                end
            end

            assign bus.phase[gi*ACC_W +: ACC_W] = phase_q;
            assign bus.active[gi]               = active_q;
            assign bus.wrap[gi]                 = wrap_q;
        end
    endgenerate
endmodule

// File: tb/tb_poly_dds_acc.sv
// Directed and randomized checks of poly_dds_acc against an arithmetic
// reference model of key timing and phase accumulation.
module tb_poly_dds_acc;
    localparam int CH     = 4;
    localparam int ACC_W  = 25;
    localparam int FCW_W  = 16;
    localparam int MULT_W = 3;
    localparam longint MOD = 64'd1 << ACC_W;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    poly_dds_acc_if #(.CH(CH), .ACC_W(ACC_W), .FCW_W(FCW_W), .MULT_W(MULT_W)) bus ();

    poly_dds_acc #(.CH(CH), .ACC_W(ACC_W), .FCW_W(FCW_W), .MULT_W(MULT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: key level seen at edge e takes effect at edge e+2.
    longint m_ph  [CH];
    longint m_stp [CH];
    bit     m_act [CH];
    bit     m_wr  [CH];
    bit     hist  [CH][4];

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_ph[c] = 0; m_stp[c] = 0; m_act[c] = 0; m_wr[c] = 0;
            for (int k = 0; k < 4; k++) hist[c][k] = 0;
        end
    endtask

    task automatic model_edge();
        longint s;
        longint mult;
        for (int c = 0; c < CH; c++) begin
            for (int k = 3; k > 0; k--) hist[c][k] = hist[c][k-1];
            hist[c][0] = bus.key_n[c];
            mult = bus.mode ? longint'(bus.mult_b) : longint'(bus.mult_a);
            m_wr[c] = 0;
            if (hist[c][3] && !hist[c][2]) begin
                m_stp[c] = longint'(bus.fcw[c*FCW_W +: FCW_W]) * mult;
                m_ph[c]  = 0;
                m_act[c] = 1;
            end else if (!hist[c][3] && hist[c][2]) begin
                m_ph[c]  = 0;
                m_act[c] = 0;
            end else if (m_act[c] && bus.tick) begin
                s       = m_ph[c] + (m_stp[c] % MOD);
                m_wr[c] = (s >= MOD);
                m_ph[c] = s % MOD;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all();
        for (int c = 0; c < CH; c++) begin
            chk($sformatf("phase ch%0d", c),  64'(bus.phase[c*ACC_W +: ACC_W]), 64'(m_ph[c]));
            chk($sformatf("active ch%0d", c), 64'(bus.active[c]), 64'(m_act[c]));
            chk($sformatf("wrap ch%0d", c),   64'(bus.wrap[c]),   64'(m_wr[c]));
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        int nwrap;
        bus.key_n  = '1;
        bus.fcw    = '0;
        bus.mult_a = '0;
        bus.mult_b = '0;
        bus.mode   = 1'b0;
        bus.tick   = 1'b0;
        rst_n      = 1'b0;
        model_reset();
        #1;
        check_all();
        repeat (3) step();
        rst_n = 1'b1;
        repeat (4) step();

        // Basic press and accumulation
        bus.fcw[0 +: FCW_W] = 16'd1000;
        bus.mult_a = 3'd3;
        bus.mode   = 1'b0;
        bus.tick   = 1'b1;
        bus.key_n[0] = 1'b0;
        step(); step();
        chk("press_not_before_edge3", 64'(bus.active[0]), 64'd0);
        step();
        chk("press_active_edge3", 64'(bus.active[0]), 64'd1);
        chk("press_phase0", 64'(bus.phase[ACC_W-1:0]), 64'd0);
        step(); chk("phase_3000", 64'(bus.phase[ACC_W-1:0]), 64'd3000);
        step(); chk("phase_6000", 64'(bus.phase[ACC_W-1:0]), 64'd6000);
        step(); chk("phase_9000", 64'(bus.phase[ACC_W-1:0]), 64'd9000);

        // Inputs changed while held do not alter the step; tick low holds phase
        bus.fcw[0 +: FCW_W] = 16'd5;
        bus.mode   = 1'b1;
        bus.mult_b = 3'd7;
        step(); chk("hold_12000", 64'(bus.phase[ACC_W-1:0]), 64'd12000);
        step(); chk("hold_15000", 64'(bus.phase[ACC_W-1:0]), 64'd15000);
        bus.tick = 1'b0;
        repeat (10) step();
        chk("tick_low_hold", 64'(bus.phase[ACC_W-1:0]), 64'd15000);
        bus.tick = 1'b1;
        step(); chk("resume_18000", 64'(bus.phase[ACC_W-1:0]), 64'd18000);

        // Simultaneous release ch0 / press ch1
        bus.fcw[FCW_W +: FCW_W] = 16'd200;
        bus.mult_a = 3'd2;
        bus.mode   = 1'b0;
        bus.key_n[0] = 1'b1;
        bus.key_n[1] = 1'b0;
        step(); step();
        chk("sim_active0_before", 64'(bus.active[0]), 64'd1);
        chk("sim_active1_before", 64'(bus.active[1]), 64'd0);
        step();
        chk("sim_active0", 64'(bus.active[0]), 64'd0);
        chk("sim_phase0",  64'(bus.phase[ACC_W-1:0]), 64'd0);
        chk("sim_active1", 64'(bus.active[1]), 64'd1);
        chk("sim_phase1",  64'(bus.phase[ACC_W +: ACC_W]), 64'd0);
        step(); chk("ch1_400", 64'(bus.phase[ACC_W +: ACC_W]), 64'd400);
        step(); chk("ch1_800", 64'(bus.phase[ACC_W +: ACC_W]), 64'd800);

        // Wrap on the 74th tick with step 458745
        bus.key_n[1] = 1'b1;
        bus.fcw[0 +: FCW_W] = 16'hFFFF;
        bus.mult_a = 3'd7;
        bus.key_n[0] = 1'b0;
        repeat (3) step();
        chk("wrap_press_active", 64'(bus.active[0]), 64'd1);
        nwrap = 0;
        for (int i = 1; i <= 73; i++) begin
            step();
            if (bus.wrap[0]) nwrap++;
        end
        chk("wrap_quiet_1_73", 64'(nwrap), 64'd0);
        step();
        chk("wrap_phase_74", 64'(bus.phase[ACC_W-1:0]), 64'd392698);
        chk("wrap_pulse_74", 64'(bus.wrap[0]), 64'd1);
        step();
        chk("wrap_clear_75", 64'(bus.wrap[0]), 64'd0);
        chk("phase_75", 64'(bus.phase[ACC_W-1:0]), 64'd851443);

        // Asynchronous reset mid-accumulation, key held low through it
        rst_n = 1'b0;
        #1;
        chk("async_rst_phase",  64'(bus.phase), 64'd0);
        chk("async_rst_active", 64'(bus.active), 64'd0);
        chk("async_rst_wrap",   64'(bus.wrap), 64'd0);
        model_reset();
        check_all();
        repeat (3) step();
        rst_n = 1'b1;
        repeat (10) step();
        chk("held_key_no_press", 64'(bus.active[0]), 64'd0);
        bus.key_n[0] = 1'b1;
        repeat (5) step();
        bus.key_n[0] = 1'b0;
        repeat (3) step();
        chk("repress_active", 64'(bus.active[0]), 64'd1);
        step();
        chk("repress_phase", 64'(bus.phase[ACC_W-1:0]), 64'd458745);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            for (int c = 0; c < CH; c++)
                if ($urandom_range(15) == 0) bus.key_n[c] = ~bus.key_n[c];
            for (int c = 0; c < CH; c++)
                bus.fcw[c*FCW_W +: FCW_W] = ($urandom_range(7) == 0) ? 16'd0 : FCW_W'($urandom);
            bus.mult_a = MULT_W'($urandom);
            bus.mult_b = MULT_W'($urandom);
            bus.mode   = 1'($urandom);
            bus.tick   = ($urandom_range(3) != 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
